// File: rtl/exu_commit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exu_commit_pkg
// Description : Shared widths, state encodings and helpers for the commit
//               stage (exu_commit and exu_commit_flush).
// Revision    : 1.0 - initial release
// ============================================================================
package exu_commit_pkg;

  localparam int XLEN       = 32;
  localparam int PC_SIZE    = 32;
  localparam int INSTR_SIZE = 32;

  // Commit FSM state encodings (2 bits)
  localparam logic [1:0] COMMIT_ST_IDLE  = 2'd0;
  localparam logic [1:0] COMMIT_ST_FLUSH = 2'd1;
  localparam logic [1:0] COMMIT_ST_HALT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = COMMIT_ST_IDLE,
    ST_FLUSH = COMMIT_ST_FLUSH,
    ST_HALT  = COMMIT_ST_HALT
  } commit_st_e;

  // Redirect target for a resolved branch/jump; wraps modulo 2^PC_SIZE.
  function automatic logic [PC_SIZE-1:0] bjp_target(
    input logic [PC_SIZE-1:0] pc,
    input logic [XLEN-1:0]    imm,
    input logic               taken
  );
    logic [PC_SIZE-1:0] t;
    if (taken) t = pc + imm[PC_SIZE-1:0];
    else       t = pc + PC_SIZE'(4);
    return t;
  endfunction

endpackage : exu_commit_pkg
`default_nettype wire

// File: rtl/exu_commit_flush.sv
`default_nettype none
// ============================================================================
// Module      : exu_commit_flush
// Description : Mispredict detection, redirect target adder and the redirect
//               register whose valid/pc are held until the IFU accepts them.
// Revision    : 1.0 - initial release
// ============================================================================
module exu_commit_flush
  import exu_commit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               acc_i,
  input  logic               pc_vld_i,
  input  logic               bjp_i,
  input  logic               prdt_i,
  input  logic               rslv_i,
  input  logic               ebreak_i,
  input  logic [PC_SIZE-1:0] pc_i,
  input  logic [XLEN-1:0]    imm_i,
  output logic               mispredict_o,
  output logic               flush_valid_o,
  input  logic               flush_ready_i,
  output logic [PC_SIZE-1:0] flush_pc_o
);

  logic               flush_valid_q, flush_valid_d;
  logic [PC_SIZE-1:0] flush_pc_q, flush_pc_d;
  logic               take;

  // ebreak wins over a simultaneous mispredict, so it suppresses detection.
  assign mispredict_o = pc_vld_i & bjp_i & (prdt_i ^ rslv_i) & ~ebreak_i;
  assign take         = acc_i & mispredict_o;

  // Load a new redirect on a mispredicting accept, drop it on handshake.
  always_comb begin
    flush_valid_d = flush_valid_q;
    flush_pc_d    = flush_pc_q;
    if (take) begin
      flush_valid_d = 1'b1;
      flush_pc_d    = bjp_target(pc_i, imm_i, rslv_i);
    end else if (flush_valid_q && flush_ready_i) begin
      flush_valid_d = 1'b0;
    end
  end

  // Redirect register; pc only changes on a new load so it stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_valid_q <= 1'b0;
      flush_pc_q    <= '0;
    end else begin
      flush_valid_q <= flush_valid_d;
      flush_pc_q    <= flush_pc_d;
    end
  end

  assign flush_valid_o = flush_valid_q;
  assign flush_pc_o    = flush_pc_q;

endmodule : exu_commit_flush
`default_nettype wire

// File: rtl/exu_commit.sv
`default_nettype none
// ============================================================================
// Module      : exu_commit
// Description : Commit stage after the ALU. Accepts one instruction per
//               handshake, counts retirements, redirects fetch on branch
//               mispredicts and halts on ebreak.
//               Optional macro EXU_COMMIT_TRACE_EN adds a retire trace port.
// Revision    : 1.0 - initial release
// ============================================================================
module exu_commit
  import exu_commit_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmt_i_valid,
  output logic                  cmt_i_ready,
  input  logic                  cmt_i_pc_vld,
  input  logic [PC_SIZE-1:0]    cmt_i_pc,
  input  logic [INSTR_SIZE-1:0] cmt_i_instr,
  input  logic [XLEN-1:0]       cmt_i_imm,
  input  logic                  cmt_i_bjp,
  input  logic                  cmt_i_bjp_prdt,
  input  logic                  cmt_i_bjp_rslv,
  input  logic                  cmt_i_ebreak,
  output logic                  flush_o_valid,
  input  logic                  flush_o_ready,
  output logic [PC_SIZE-1:0]    flush_o_pc,
`ifdef EXU_COMMIT_TRACE_EN
  output logic                  trc_o_valid,
  output logic [PC_SIZE-1:0]    trc_o_pc,
  output logic [INSTR_SIZE-1:0] trc_o_instr,
`endif
  output logic                  halt_o,
  output logic [CNT_W-1:0]      minstret_o
);

  commit_st_e       state_q, state_d;
  logic             acc;
  logic             retire;
  logic             mispredict;
  logic [CNT_W-1:0] minstret_q;

  // Ready depends on state alone, never on cmt_i_valid.
  assign cmt_i_ready = (state_q == ST_IDLE);
  assign acc         = cmt_i_valid & cmt_i_ready;
  assign retire      = acc & cmt_i_pc_vld;
  assign halt_o      = (state_q == ST_HALT);

  exu_commit_flush u_flush (
    .clk           (clk),
    .rst           (rst),
    .acc_i         (acc),
    .pc_vld_i      (cmt_i_pc_vld),
    .bjp_i         (cmt_i_bjp),
    .prdt_i        (cmt_i_bjp_prdt),
    .rslv_i        (cmt_i_bjp_rslv),
    .ebreak_i      (cmt_i_ebreak),
    .pc_i          (cmt_i_pc),
    .imm_i         (cmt_i_imm),
    .mispredict_o  (mispredict),
    .flush_valid_o (flush_o_valid),
    .flush_ready_i (flush_o_ready),
    .flush_pc_o    (flush_o_pc)
  );

  // Next-state: ebreak has priority over mispredict; HALT is terminal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (retire && cmt_i_ebreak) state_d = ST_HALT;
        else if (acc && mispredict) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_o_ready) state_d = ST_IDLE;
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Retired-instruction counter; bubbles are not counted, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         minstret_q <= '0;
    else if (retire) minstret_q <= minstret_q + CNT_W'(1);
  end

  assign minstret_o = minstret_q;

`ifdef EXU_COMMIT_TRACE_EN
  logic                  trc_valid_q;
  logic [PC_SIZE-1:0]    trc_pc_q;
  logic [INSTR_SIZE-1:0] trc_instr_q;

  // One-cycle trace pulse per retired instruction, pc/instr captured with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trc_valid_q <= 1'b0;
      trc_pc_q    <= '0;
      trc_instr_q <= '0;
    end else begin
      trc_valid_q <= retire;
      if (retire) begin
        trc_pc_q    <= cmt_i_pc;
        trc_instr_q <= cmt_i_instr;
      end
    end
  end

  assign trc_o_valid = trc_valid_q;
  assign trc_o_pc    = trc_pc_q;
  assign trc_o_instr = trc_instr_q;
`else
  logic unused_instr;
  assign unused_instr = ^cmt_i_instr;
`endif

endmodule : exu_commit
`default_nettype wire

// File: tb/tb_exu_commit.sv
`default_nettype none
// ============================================================================
// Module      : tb_exu_commit
// Description : Self-checking bench for exu_commit: directed stimulus, a
//               behavioural reference model and a per-cycle compare process.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exu_commit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0, pc_vld = 1'b0, bjp = 1'b0, prdt = 1'b0;
  logic        rslv = 1'b0, ebreak = 1'b0, fready = 1'b0;
  logic [31:0] pc = '0, instr = '0, imm = '0;

  wire         ready, fvalid, halt;
  wire  [31:0] fpc;
  wire  [63:0] minstret;
  wire         ready2, fvalid2, halt2;
  wire  [31:0] fpc2;
  wire  [2:0]  minstret2;
`ifdef EXU_COMMIT_TRACE_EN
  wire         tvalid, tvalid2;
  wire  [31:0] tpc, tinstr, tpc2, tinstr2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exu_commit dut (
    .clk(clk), .rst(rst),
    .cmt_i_valid(valid), .cmt_i_ready(ready), .cmt_i_pc_vld(pc_vld),
    .cmt_i_pc(pc), .cmt_i_instr(instr), .cmt_i_imm(imm),
    .cmt_i_bjp(bjp), .cmt_i_bjp_prdt(prdt), .cmt_i_bjp_rslv(rslv),
    .cmt_i_ebreak(ebreak),
    .flush_o_valid(fvalid), .flush_o_ready(fready), .flush_o_pc(fpc),
`ifdef EXU_COMMIT_TRACE_EN
    .trc_o_valid(tvalid), .trc_o_pc(tpc), .trc_o_instr(tinstr),
`endif
    .halt_o(halt), .minstret_o(minstret)
  );

  // Narrow-counter instance sharing the same stimulus: exercises wrap to 0.
  exu_commit #(.CNT_W(3)) dut_w (
    .clk(clk), .rst(rst),
    .cmt_i_valid(valid), .cmt_i_ready(ready2), .cmt_i_pc_vld(pc_vld),
    .cmt_i_pc(pc), .cmt_i_instr(instr), .cmt_i_imm(imm),
    .cmt_i_bjp(bjp), .cmt_i_bjp_prdt(prdt), .cmt_i_bjp_rslv(rslv),
    .cmt_i_ebreak(ebreak),
    .flush_o_valid(fvalid2), .flush_o_ready(fready), .flush_o_pc(fpc2),
`ifdef EXU_COMMIT_TRACE_EN
    .trc_o_valid(tvalid2), .trc_o_pc(tpc2), .trc_o_instr(tinstr2),
`endif
    .halt_o(halt2), .minstret_o(minstret2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: "halted", "redirect pending" and a plain retire count.
  logic        m_halted, m_redirect;
  logic [31:0] m_target;
  logic [63:0] m_count;
  logic        m_tv;
  logic [31:0] m_tpc, m_tinstr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_halted <= 1'b0; m_redirect <= 1'b0; m_target <= '0; m_count <= '0;
      m_tv <= 1'b0; m_tpc <= '0; m_tinstr <= '0;
    end else begin
      m_tv <= 1'b0;
      if (!m_halted && !m_redirect && valid) begin
        if (pc_vld) begin
          m_count <= m_count + 64'd1;
          m_tv <= 1'b1; m_tpc <= pc; m_tinstr <= instr;
          if (ebreak)
            m_halted <= 1'b1;
          else if (bjp && (prdt != rslv)) begin
            m_redirect <= 1'b1;
            m_target   <= rslv ? pc + imm : pc + 32'd4;
          end
        end
      end else if (m_redirect && fready) begin
        m_redirect <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready", {63'd0, ready}, {63'd0, !(m_halted || m_redirect)});
      check("flush_valid", {63'd0, fvalid}, {63'd0, m_redirect});
      check("halt", {63'd0, halt}, {63'd0, m_halted});
      check("minstret", minstret, m_count);
      check("minstret_w", {61'd0, minstret2}, {61'd0, m_count[2:0]});
      if (m_redirect) check("flush_pc", {32'd0, fpc}, {32'd0, m_target});
`ifdef EXU_COMMIT_TRACE_EN
      check("trc_valid", {63'd0, tvalid}, {63'd0, m_tv});
      if (m_tv) begin
        check("trc_pc", {32'd0, tpc}, {32'd0, m_tpc});
        check("trc_instr", {32'd0, tinstr}, {32'd0, m_tinstr});
      end
`endif
    end
  end

  task automatic set_in(input logic v, input logic pv, input logic [31:0] p,
                        input logic [31:0] im, input logic b, input logic pr,
                        input logic rs, input logic eb);
    valid = v; pc_vld = pv; pc = p; imm = im; bjp = b; prdt = pr; rslv = rs;
    ebreak = eb; instr = p ^ 32'h0013_0013;
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  initial begin
    // Reset values while rst is held.
    #3;
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_flush_valid", {63'd0, fvalid}, 64'd0);
    check("rst_flush_pc", {32'd0, fpc}, 64'd0);
    check("rst_halt", {63'd0, halt}, 64'd0);
    check("rst_minstret", minstret, 64'd0);
    tick(); tick();
    rst = 1'b0;

    // Five back-to-back plain retires.
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 32'h0000_1000 + 32'(i * 4), 0, 0, 0, 0, 0);
      tick();
      check("b2b_count", minstret, 64'(i + 1));
      check("b2b_ready", {63'd0, ready}, 64'd1);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);

    // Mispredict, resolved taken, IFU stalls 3 cycles.
    fready = 1'b0;
    tick();
    set_in(1, 1, 32'h8000_0010, 32'h20, 1, 0, 1, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 4) fready = 1'b1;
      #1;
      check("mp1_valid", {63'd0, fvalid}, 64'd1);
      check("mp1_pc", {32'd0, fpc}, 64'h8000_0030);
      check("mp1_ready", {63'd0, ready}, 64'd0);
    end
    @(negedge clk); #1;
    check("mp1_after_valid", {63'd0, fvalid}, 64'd0);
    check("mp1_after_ready", {63'd0, ready}, 64'd1);
    check("mp1_count", minstret, 64'd6);

    // Mispredict, resolved not-taken, IFU ready immediately.
    @(posedge clk); #2;
    set_in(1, 1, 32'h8000_0100, 32'h40, 1, 1, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    check("mp2_valid", {63'd0, fvalid}, 64'd1);
    check("mp2_pc", {32'd0, fpc}, 64'h8000_0104);
    check("mp2_ready", {63'd0, ready}, 64'd0);
    @(negedge clk); #1;
    check("mp2_after_valid", {63'd0, fvalid}, 64'd0);
    check("mp2_after_ready", {63'd0, ready}, 64'd1);

    // Bubble carrying ebreak and a mispredict: fully discarded.
    @(posedge clk); #2;
    set_in(1, 0, 32'h8000_0200, 32'h8, 1, 0, 1, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    check("bubble_count", minstret, 64'd7);
    check("bubble_halt", {63'd0, halt}, 64'd0);
    check("bubble_flush", {63'd0, fvalid}, 64'd0);

    // Eighth retire wraps the 3-bit counter.
    set_in(1, 1, 32'h0000_2000, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    check("wrap_narrow", {61'd0, minstret2}, 64'd0);
    check("wrap_wide", minstret, 64'd8);

    // Reset pulse in the middle of a redirect.
    fready = 1'b0;
    set_in(1, 1, 32'h8000_0300, 32'h10, 1, 0, 1, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    check("rstmid_pre_valid", {63'd0, fvalid}, 64'd1);
    rst = 1'b1; #1;
    check("rstmid_valid", {63'd0, fvalid}, 64'd0);
    check("rstmid_ready", {63'd0, ready}, 64'd1);
    check("rstmid_pc", {32'd0, fpc}, 64'd0);
    check("rstmid_count", minstret, 64'd0);
    #1 rst = 1'b0;

    // ebreak also flagged as mispredict: halt wins, no redirect.
    fready = 1'b1;
    tick();
    set_in(1, 1, 32'h8000_0400, 32'h80, 1, 1, 0, 1);
    tick();
    check("ebk_halt", {63'd0, halt}, 64'd1);
    check("ebk_flush", {63'd0, fvalid}, 64'd0);
    check("ebk_count", minstret, 64'd1);
    // Keep offering work: nothing may be accepted while halted.
    set_in(1, 1, 32'h8000_0500, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) tick();
    check("halted_ready", {63'd0, ready}, 64'd0);
    check("halted_count", minstret, 64'd1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; #1;
    check("unhalt_ready", {63'd0, ready}, 64'd1);
    check("unhalt_halt", {63'd0, halt}, 64'd0);
    #1 rst = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_exu_commit
`default_nettype wire
